odd_number_gen: RTL

- Sequential source that streams ascending odd numbers over a programmed inclusive range.
- Sits directly upstream of odd_number and drives its num input.
- Uses a valid/ready handshake so downstream checkers and loggers can apply backpressure.
- Reports how many values were emitted, plus done and empty-range error status.

---
 rtl/odd_number_gen_pkg.sv | 15 +
 rtl/odd_number_gen_if.sv | 31 +++
 rtl/odd_number_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/odd_number_gen_pkg.sv
// ---------------------------------------------------------------------------
// odd_number_gen_pkg
//   Shared constants for the odd number generator.
//   - ODD_W            : default data width of the generated stream
//   - ST_IDLE/RUN/FIN  : 2-bit sequencer state encodings
// ---------------------------------------------------------------------------
package odd_number_gen_pkg;

  localparam int ODD_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

endpackage : odd_number_gen_pkg

// File: rtl/odd_number_gen_if.sv
// ---------------------------------------------------------------------------
// odd_number_gen_if
//   Valid/ready stream carrying one odd value per transfer.
//   - num       : current odd value
//   - num_valid : num holds a valid value
//   - num_ready : consumer accepts num this cycle
//   master = producer (odd_number_gen), slave = consumer.
// ---------------------------------------------------------------------------
interface odd_number_gen_if
  import odd_number_gen_pkg::*;
#(
  parameter int W = ODD_W
);

  logic [W-1:0] num;
  logic         num_valid;
  logic         num_ready;

  modport master (
    output num,
    output num_valid,
    input  num_ready
  );

  modport slave (
    input  num,
    input  num_valid,
    output num_ready
  );

endinterface : odd_number_gen_if

// File: rtl/odd_number_gen.sv
// ---------------------------------------------------------------------------
// odd_number_gen
//   Streams ascending odd numbers over an inclusive [start_val, end_val]
//   range through a valid/ready handshake, then pulses done.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; count/err/num hold last sequence result
//   RUN   | num_valid high, advancing by 2 on each transfer
//   FIN   | one-cycle done pulse, returns to IDLE
//
//   Ports:
//   - clk, rst          : clock, asynchronous active-high reset
//   - start, abort      : begin a sequence / terminate a running one
//   - start_val,end_val : range bounds, sampled on accepted start
//   - stream (master)   : num / num_valid / num_ready
//   - count             : values transferred in current or last sequence
//   - busy, done, err   : status (busy in RUN/FIN, done pulse, empty range)
// ---------------------------------------------------------------------------
module odd_number_gen
  import odd_number_gen_pkg::*;
#(
  parameter int W = ODD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [W-1:0]              start_val,
  input  logic [W-1:0]              end_val,
  odd_number_gen_if.master          stream,
  output logic [W-1:0]              count,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  logic [1:0]   state;
  logic [1:0]   state_nxt;

  logic [W-1:0] end_q;
  logic [W-1:0] num_q;
  logic         valid_q;
  logic [W-1:0] count_q;
  logic         err_q;

  logic [W-1:0] first;
  logic         empty_range;
  logic         xfer;
  logic [W:0]   nxt_w;
  logic         run_last;

  // Forcing bit 0 rounds an even bound up; an even 2^W-2 becomes 2^W-1,
  // so this can never overflow.
  assign first       = start_val | W'(1);
  assign empty_range = (first > end_val);

  assign xfer = valid_q & stream.num_ready;

  // Increment carried at W+1 bits so a step past 2^W-1 is caught instead
  // of wrapping back to a small odd value.
  assign nxt_w    = {1'b0, num_q} + (W+1)'(2);
  assign run_last = nxt_w[W] | (nxt_w > {1'b0, end_q});

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = empty_range ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort || (xfer && run_last)) begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    busy             = (state != ST_IDLE);
    done             = (state == ST_FIN);
    stream.num       = num_q;
    stream.num_valid = valid_q;
    count            = count_q;
    err              = err_q;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            end_q   <= end_val;
            count_q <= '0;
            err_q   <= empty_range;
            // On an empty range num keeps the previous sequence's value.
            if (!empty_range) begin
              num_q   <= first;
              valid_q <= 1'b1;
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          // A transfer coinciding with abort still counts: the consumer
          // has already taken num.
          if (xfer) begin
            count_q <= count_q + W'(1);
          end
          if (abort) begin
            valid_q <= 1'b0;
          end else if (xfer) begin
            if (run_last) begin
              valid_q <= 1'b0;
            end else begin
              num_q <= nxt_w[W-1:0];
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- protocol checks ----------------
  // A stalled value must stay put until the consumer takes it.
  a_stall_hold : assert property (@(posedge clk) disable iff (rst)
    (state == ST_RUN && valid_q && !stream.num_ready && !abort)
      |=> (valid_q && $stable(num_q)));

  // Only odd values are ever offered.
  a_odd_only : assert property (@(posedge clk) disable iff (rst)
    valid_q |-> num_q[0]);

  // num_valid is high exactly in RUN.
  a_valid_run : assert property (@(posedge clk) disable iff (rst)
    valid_q == (state == ST_RUN));

endmodule : odd_number_gen
